// File: rtl/ceespu_pkg.sv
// Shared ceespu definitions: muldiv op codes and muldiv FSM encoding.
// Decode imports the same package so ALU and muldiv op selection agree.
package ceespu_pkg;

  localparam logic [2:0] MD_OP_MUL    = 3'd0;
  localparam logic [2:0] MD_OP_MULH   = 3'd1;
  localparam logic [2:0] MD_OP_MULHSU = 3'd2;
  localparam logic [2:0] MD_OP_MULHU  = 3'd3;
  localparam logic [2:0] MD_OP_DIV    = 3'd4;
  localparam logic [2:0] MD_OP_DIVU   = 3'd5;
  localparam logic [2:0] MD_OP_REM    = 3'd6;
  localparam logic [2:0] MD_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE     = 2'd0,
    MD_MUL_WAIT = 2'd1,
    MD_DIV_ITER = 2'd2,
    MD_DIV_FIX  = 2'd3
  } md_state_e;

  // Op field decoding: bit 2 selects the divider, bit 1 remainder, bit 0 unsigned.
  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input logic [2:0] op);
    return op[1];
  endfunction

  function automatic logic md_div_signed(input logic [2:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/ceespu_muldiv_if.sv
// Request/response bundle between the execute stage and the muldiv unit.
interface ceespu_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, op, data_a, data_b, flush,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, data_a, data_b, flush,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/ceespu_div_core.sv
// Iterative radix-2 restoring divider on operand magnitudes; one quotient bit per cycle.
// Sign correction of the results is left to the instantiating unit.
module ceespu_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic             flush,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q, done_q;
  logic [WIDTH-1:0] a_abs_c, b_abs_c;
  logic [WIDTH:0]   trial_c;

  assign a_abs_c = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_abs_c = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign trial_c = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  // quo_q shifts dividend bits out at the top while quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        active_q <= 1'b0;
      end else if (start) begin
        quo_q    <= a_abs_c;
        rem_q    <= '0;
        dvs_q    <= b_abs_c;
        cnt_q    <= CNT_W'(WIDTH - 1);
        active_q <= 1'b1;
      end else if (active_q) begin
        if (!trial_c[WIDTH]) begin
          rem_q <= trial_c[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/ceespu_muldiv.sv
// ceespu multiply/divide unit: pipelined multiplier plus iterative divider behind a
// start/busy/done handshake with fixed, op-dependent latency.
module ceespu_muldiv
  import ceespu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 3
) (
  input logic             I_clk,
  input logic             I_rst_n,
  ceespu_muldiv_if.slave  bus
);

  localparam int unsigned CNT_W         = $clog2(WIDTH);
  localparam int unsigned MUL_WAIT_INIT = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rem_op_q, rem_op_d;
  logic             dbz_q, dbz_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             div_start_c;

  // Multiplier: sign/zero-extend to 2*WIDTH, low 2*WIDTH bits of the product are exact.
  logic             a_sgn_c, b_sgn_c;
  logic [2*WIDTH-1:0] a_ext_c, b_ext_c, prod_c;
  logic [WIDTH-1:0] mul_sel_c, mul_out_c;

  assign a_sgn_c   = ((bus.op == MD_OP_MULH) || (bus.op == MD_OP_MULHSU)) && bus.data_a[WIDTH-1];
  assign b_sgn_c   = (bus.op == MD_OP_MULH) && bus.data_b[WIDTH-1];
  assign a_ext_c   = {{WIDTH{a_sgn_c}}, bus.data_a};
  assign b_ext_c   = {{WIDTH{b_sgn_c}}, bus.data_b};
  assign prod_c    = a_ext_c * b_ext_c;
  assign mul_sel_c = (bus.op == MD_OP_MUL) ? prod_c[WIDTH-1:0] : prod_c[2*WIDTH-1:WIDTH];

  // Free-running shift pipeline; the FSM picks up the entry for the accepted op on time.
  if (MUL_STAGES == 1) begin : g_mul_direct
    assign mul_out_c = mul_sel_c;
  end else begin : g_mul_pipe
    logic [WIDTH-1:0] pipe_q [MUL_STAGES-1];
    always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
        for (int i = 0; i < int'(MUL_STAGES) - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= mul_sel_c;
        for (int i = 1; i < int'(MUL_STAGES) - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign mul_out_c = pipe_q[MUL_STAGES-2];
  end

  logic [WIDTH-1:0] div_quo, div_rem, div_fix_c;
  logic             div_done, b_zero_c, div_signed_c;

  assign b_zero_c     = (bus.data_b == '0);
  assign div_signed_c = md_div_signed(bus.op);

  ceespu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (I_clk),
    .rst_n     (I_rst_n),
    .start     (div_start_c),
    .dividend  (bus.data_a),
    .divisor   (bus.data_b),
    .is_signed (div_signed_c),
    .flush     (bus.flush),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Quotient negated on differing signs (not for /0); remainder follows the dividend.
  assign div_fix_c = rem_op_q ? (r_neg_q ? -div_rem : div_rem)
                              : (q_neg_q ? -div_quo : div_quo);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q       <= MD_IDLE;
      cnt_q         <= '0;
      rem_op_q      <= 1'b0;
      dbz_q         <= 1'b0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_op_q      <= rem_op_d;
      dbz_q         <= dbz_d;
      q_neg_q       <= q_neg_d;
      r_neg_q       <= r_neg_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_q      <= result_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_op_d      = rem_op_q;
    dbz_d         = dbz_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    result_d      = result_q;
    div_by_zero_d = div_by_zero_q;
    div_start_c   = 1'b0;
    if (bus.flush) begin
      state_d = MD_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (bus.start) begin
            if (md_is_div(bus.op)) begin
              state_d     = MD_DIV_ITER;
              cnt_d       = CNT_W'(WIDTH - 1);
              busy_d      = 1'b1;
              div_start_c = 1'b1;
              rem_op_d    = md_is_rem(bus.op);
              dbz_d       = b_zero_c;
              q_neg_d     = div_signed_c && (bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1]) && !b_zero_c;
              r_neg_d     = div_signed_c && bus.data_a[WIDTH-1];
            end else if (MUL_STAGES == 1) begin
              done_d        = 1'b1;
              result_d      = mul_out_c;
              div_by_zero_d = 1'b0;
            end else begin
              state_d = MD_MUL_WAIT;
              cnt_d   = CNT_W'(MUL_WAIT_INIT);
              busy_d  = 1'b1;
            end
          end
        end
        MD_MUL_WAIT: begin
          if (cnt_q == '0) begin
            state_d       = MD_IDLE;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            result_d      = mul_out_c;
            div_by_zero_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        MD_DIV_ITER: begin
          if (cnt_q == '0) state_d = MD_DIV_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        MD_DIV_FIX: begin
          if (div_done) begin
            state_d       = MD_IDLE;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            result_d      = div_fix_c;
            div_by_zero_d = dbz_q;
          end
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: doc/ceespu_muldiv.md
# ceespu_muldiv

Parametrised multiply/divide unit for the ceespu execute stage, placed alongside the ALU and selected for multi-cycle operations. It takes operand pairs with a start/busy/done handshake. It returns low or high product halves through a pipelined multiplier, and quotient or remainder through an iterative radix-2 divider, with a fixed, op-dependent latency. It adds signed/unsigned high-half multiply, division, remainder, a flush input and defined divide-by-zero/overflow results.

## Interface
- WIDTH, 32, operand/result width (≥ 8, even)
- MUL_STAGES, 3, multiplier pipeline depth (1–4); multiply latency in cycles
- I_clk  in  1  clock, rising edge
- I_rst_n  in  1  asynchronous active-low reset
- I_start  in  1  launch operation; accepted only when O_busy = 0
- I_op  in  3  operation code (MD_OP_* from ceespu_pkg)
- I_dataA  in  WIDTH  operand A / dividend
- I_dataB  in  WIDTH  operand B / divisor
- I_flush  in  1  abandon current operation (pipeline flush)
- O_busy  out  1  operation in flight
- O_done  out  1  single-cycle pulse, O_result valid
- O_result  out  WIDTH  result, held until next O_done
- O_divByZero  out  1  valid with O_done; divisor was zero on a DIV/DIVU/REM/REMU

## Operation
- Ops: MUL=0 (low half), MULH=1 (signed×signed high), MULHSU=2 (signed A × unsigned B high), MULHU=3 (unsigned high), DIV=4, DIVU=5, REM=6, REMU=7.
- Reset: O_busy=0, O_done=0, O_result=0, O_divByZero=0, FSM=IDLE, all internal registers zero.
- FSM states: IDLE, MUL_WAIT, DIV_ITER, DIV_FIX.
- IDLE: I_start=1 latches op/operands, sets O_busy=1, and goes to MUL_WAIT for ops 0–3 or DIV_ITER for ops 4–7.
- MUL_WAIT: counts MUL_STAGES−1 cycles. The multiplier forms the 2·WIDTH product of sign- or zero-extended operands, and the op selects the half.
- DIV_ITER: WIDTH iterations of restoring division on the absolute values (signed ops) or raw values (unsigned ops), then goes to DIV_FIX.
- DIV_FIX: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Completion: next state IDLE, O_done=1 for one cycle, O_busy=0 in that same cycle.
- Divide by zero: quotient = all ones; remainder = dividend; O_divByZero=1.
- Signed overflow (A = most-negative, B = −1): DIV gives most-negative, REM gives 0, O_divByZero=0.
- Special cases keep the normal latency; there is no early exit.
- I_start while O_busy=1 is ignored; no queueing.
- I_flush=1 in any state: next state IDLE, O_busy=0, no O_done, and O_result keeps its old value.
- I_flush and I_start in the same cycle from IDLE: flush wins, nothing is launched.
- Reset mid-operation aborts immediately, with no O_done.
- Arithmetic is modulo 2^WIDTH and width-generic; no hardcoded 32.

## Timing
- The start cycle is cycle 0.
- Multiply: O_done in cycle MUL_STAGES.
- Divide/remainder: O_done in cycle WIDTH+2 (one cycle setup/abs, WIDTH iterations, one cycle fix). WIDTH=32 gives cycle 34.
- O_busy is high in cycles 1 … done-cycle−1.
- Earliest next I_start is the O_done cycle; back-to-back issue is permitted there.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- ceespu_pkg holds the MD_OP_* localparams (3-bit) and the FSM state encoding. The same package is shared with decode so that ALU and muldiv op selection agree.
- Sub-module ceespu_div_core (parameter WIDTH) holds the iterative restoring divider. Its interface:
  - inputs: start, dividend, divisor, signed flag, flush
  - outputs: quotient, remainder, done
- The multiplier stays inline as a registered pipeline whose depth is set by MUL_STAGES, so that the synthesizer infers DSP blocks.

## Test plan
- WIDTH=32, MUL_STAGES=3. MUL with A=0xFFFFFFFF, B=2 → O_done in cycle 3, O_result=0xFFFFFFFE. MULHU on the same operands → 0x00000001. MULH → 0xFFFFFFFF.
- DIV A=−7 (0xFFFFFFF9), B=2 → cycle 34 O_result=0xFFFFFFFD (−3). REM → 0xFFFFFFFF (−1). DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF with O_divByZero=1. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM on the same operands → 0, O_divByZero=0, latency still 34.
- DIV started, I_flush in cycle 10 → O_busy=0 in cycle 11, no O_done, O_result unchanged. I_start while busy → ignored, with the original result still arriving on time.
- I_rst_n asserted in cycle 5 of a DIV → outputs zero immediately (asynchronous), no O_done after release. Back-to-back MUL issued in the O_done cycle → second O_done exactly MUL_STAGES cycles later.
- Random regression against a reference model over all 8 ops, with WIDTH ∈ {8, 16, 32} and MUL_STAGES ∈ {1, 4}.
